// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: assembles an opcode plus 0-2 little-endian operand
// bytes from program memory, pulses the PC increment per byte, and hands off via valid/ready.
module fetch_seq #(
  parameter int DELAY_RISE = 0,
  parameter int DELAY_FALL = 0
) (
  input  logic        CLK,
  input  logic        RST_bar,
  input  logic [7:0]  MEM_DATA,
  input  logic        MEM_WAIT,
  input  logic        FLUSH,
  input  logic        INSN_READY,
  output logic        PC_INC,
  output logic        INSN_VALID,
  output logic [7:0]  OPCODE,
  output logic [15:0] OPERAND,
  output logic [1:0]  STATE
);

  localparam int unsigned OPW = 8;
  localparam int unsigned ARGW = 16;

  // Propagation delays are a simulation-model notion; this model is zero-delay.
  if (DELAY_RISE < 0 || DELAY_FALL < 0) begin : g_bad_delay
    $error("fetch_seq: DELAY_RISE/DELAY_FALL must be non-negative");
  end

  typedef enum logic [1:0] {
    FETCH_OP = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    VALID    = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [OPW-1:0]    opcode_q, opcode_d;
  logic [ARGW-1:0]   operand_q, operand_d;
  logic              insn_valid_q;
  logic              byte_take;

  // Next-state and latch decisions; FLUSH wins over waits and handshake.
  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    byte_take = 1'b0;
    if (FLUSH) begin
      state_d = FETCH_OP;
    end else begin
      case (state_q)
        FETCH_OP: begin
          if (!MEM_WAIT) begin
            byte_take = 1'b1;
            opcode_d  = MEM_DATA;
            state_d   = (MEM_DATA[7:6] == 2'b00) ? VALID : FETCH_LO;
          end
        end
        FETCH_LO: begin
          if (!MEM_WAIT) begin
            byte_take = 1'b1;
            operand_d = {8'h00, MEM_DATA};
            state_d   = (opcode_q[7:6] == 2'b01) ? VALID : FETCH_HI;
          end
        end
        FETCH_HI: begin
          if (!MEM_WAIT) begin
            byte_take = 1'b1;
            operand_d = {MEM_DATA, operand_q[7:0]};
            state_d   = VALID;
          end
        end
        VALID: begin
          if (INSN_READY) begin
            state_d = FETCH_OP;
          end
        end
        default: state_d = FETCH_OP;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_bar) begin
      state_q      <= FETCH_OP;
      opcode_q     <= '0;
      operand_q    <= '0;
      insn_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      opcode_q     <= opcode_d;
      operand_q    <= operand_d;
      insn_valid_q <= (state_d == VALID);
    end
  end

  // Increment must settle before the edge that latches the byte.
  assign PC_INC     = RST_bar & byte_take;
  assign INSN_VALID = insn_valid_q;
  assign OPCODE     = opcode_q;
  assign OPERAND    = operand_q;
  assign STATE      = state_q;

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: hand-computed vectors checked with immediate assertions.
module tb_fetch_seq;

  logic        CLK = 1'b0;
  logic        RST_bar;
  logic [7:0]  MEM_DATA;
  logic        MEM_WAIT;
  logic        FLUSH;
  logic        INSN_READY;
  logic        PC_INC;
  logic        INSN_VALID;
  logic [7:0]  OPCODE;
  logic [15:0] OPERAND;
  logic [1:0]  STATE;

  int vectors = 0;
  int miscompares = 0;

  fetch_seq #(.DELAY_RISE(0), .DELAY_FALL(0)) dut (
    .CLK        (CLK),
    .RST_bar    (RST_bar),
    .MEM_DATA   (MEM_DATA),
    .MEM_WAIT   (MEM_WAIT),
    .FLUSH      (FLUSH),
    .INSN_READY (INSN_READY),
    .PC_INC     (PC_INC),
    .INSN_VALID (INSN_VALID),
    .OPCODE     (OPCODE),
    .OPERAND    (OPERAND),
    .STATE      (STATE)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle 1ns past it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Settle combinational PC_INC after inputs change, then check it.
  task automatic chk_inc(input string tag, input logic exp);
    #1;
    chk(tag, 16'(PC_INC), 16'(exp));
  endtask

  task automatic chk_regs(input string tag, input logic [1:0] st, input logic v,
                          input logic [7:0] op, input logic [15:0] arg);
    chk({tag, ".state"}, 16'(STATE), 16'(st));
    chk({tag, ".valid"}, 16'(INSN_VALID), 16'(v));
    chk({tag, ".opcode"}, 16'(OPCODE), 16'(op));
    chk({tag, ".operand"}, OPERAND, arg);
  endtask

  initial begin
    RST_bar = 1'b1; MEM_DATA = 8'hC7; MEM_WAIT = 1'b0; FLUSH = 1'b0; INSN_READY = 1'b0;
    // Wander into an arbitrary state before resetting.
    tick(); tick();
    RST_bar = 1'b0;
    tick(); tick();
    chk_inc("rst.pc_inc", 1'b0);
    chk_regs("rst", 2'd0, 1'b0, 8'h00, 16'h0000);

    // Zero-operand instruction.
    RST_bar = 1'b1; MEM_DATA = 8'h05; INSN_READY = 1'b1;
    chk_inc("n0.pc_inc", 1'b1);
    tick();
    chk_regs("n0", 2'd3, 1'b1, 8'h05, 16'h0000);
    MEM_DATA = 8'hEE;
    chk_inc("n0.valid_inc", 1'b0);
    tick();
    chk("n0.back", 16'(STATE), 16'd0);
    chk("n0.back_valid", 16'(INSN_VALID), 16'd0);

    // Two-byte operand with a held-off consumer.
    INSN_READY = 1'b0; MEM_DATA = 8'h8A;
    chk_inc("n2.inc0", 1'b1);
    tick();
    chk_regs("n2.op", 2'd1, 1'b0, 8'h8A, 16'h0000);
    MEM_DATA = 8'h34;
    chk_inc("n2.inc1", 1'b1);
    tick();
    chk_regs("n2.lo", 2'd2, 1'b0, 8'h8A, 16'h0034);
    MEM_DATA = 8'h12;
    chk_inc("n2.inc2", 1'b1);
    tick();
    chk_regs("n2.hi", 2'd3, 1'b1, 8'h8A, 16'h1234);
    for (int i = 0; i < 4; i++) begin
      MEM_DATA = 8'(8'h50 + i);
      MEM_WAIT = i[0];
      chk_inc("n2.hold_inc", 1'b0);
      tick();
      chk_regs("n2.hold", 2'd3, 1'b1, 8'h8A, 16'h1234);
    end
    MEM_WAIT = 1'b0; INSN_READY = 1'b1;
    tick();
    chk("n2.accept", 16'(STATE), 16'd0);

    // One-byte operand with two wait cycles before the operand.
    INSN_READY = 1'b0; MEM_DATA = 8'h41;
    chk_inc("w.inc_op", 1'b1);
    tick();
    chk_regs("w.op", 2'd1, 1'b0, 8'h41, 16'h1234);
    for (int i = 0; i < 2; i++) begin
      MEM_WAIT = 1'b1; MEM_DATA = 8'hEE;
      chk_inc("w.wait_inc", 1'b0);
      tick();
      chk_regs("w.wait", 2'd1, 1'b0, 8'h41, 16'h1234);
    end
    MEM_WAIT = 1'b0; MEM_DATA = 8'h7F;
    chk_inc("w.inc_lo", 1'b1);
    tick();
    chk_regs("w.done", 2'd3, 1'b1, 8'h41, 16'h007F);
    INSN_READY = 1'b1;
    tick();

    // Flush in FETCH_LO, even with a wait pending.
    INSN_READY = 1'b0; MEM_DATA = 8'h80;
    tick();
    chk_regs("f.op", 2'd1, 1'b0, 8'h80, 16'h007F);
    FLUSH = 1'b1; MEM_WAIT = 1'b1; MEM_DATA = 8'h99;
    chk_inc("f.inc", 1'b0);
    tick();
    chk_regs("f.flushed", 2'd0, 1'b0, 8'h80, 16'h007F);
    FLUSH = 1'b0; MEM_WAIT = 1'b0; MEM_DATA = 8'h00;
    chk_inc("f.next_inc", 1'b1);
    tick();
    chk_regs("f.next", 2'd3, 1'b1, 8'h00, 16'h007F);

    // Taken branch while VALID: accept and restart.
    FLUSH = 1'b1; INSN_READY = 1'b1;
    chk_inc("fv.inc", 1'b0);
    tick();
    chk_regs("fv", 2'd0, 1'b0, 8'h00, 16'h007F);
    FLUSH = 1'b0; INSN_READY = 1'b0;

    // Reset while in FETCH_HI.
    MEM_DATA = 8'hC0;
    tick();
    MEM_DATA = 8'h11;
    tick();
    chk_regs("r.hi", 2'd2, 1'b0, 8'hC0, 16'h0011);
    RST_bar = 1'b0; MEM_DATA = 8'h22;
    chk_inc("r.inc", 1'b0);
    tick();
    chk_regs("r.done", 2'd0, 1'b0, 8'h00, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer sitting directly downstream of the 16-bit program-counter address register. The PC value addresses program memory; this block takes the returned byte each cycle and assembles an opcode plus a 0–2 byte little-endian operand. It drives the PC's synchronous increment line, one pulse per byte consumed, and presents the finished instruction to the control unit through a valid/ready handshake.

## Interface
Parameters:
- DELAY_RISE, 0, rise propagation delay applied to registered outputs (simulation only)
- DELAY_FALL, 0, fall propagation delay applied to registered outputs (simulation only)

Ports:
- CLK  input  1  clock; all state changes on rising edge
- RST_bar  input  1  reset; synchronous and active-low
- MEM_DATA  input  8  byte read from program memory at current PC
- MEM_WAIT  input  1  high: MEM_DATA not valid this cycle
- FLUSH  input  1  branch taken; the control unit loads the PC this edge
- INSN_READY  input  1  control unit accepts the presented instruction
- PC_INC  output  1  to PC register INC; combinational
- INSN_VALID  output  1  OPCODE/OPERAND hold a complete instruction
- OPCODE  output  8  latched opcode byte
- OPERAND  output  16  latched operand, {hi, lo}
- STATE  output  2  current state, for LED display

## Operation
- States (STATE encoding): FETCH_OP=0, FETCH_LO=1, FETCH_HI=2, VALID=3.
- Operand byte count n = OPCODE[7:6]: 00→0, 01→1, 10 and 11→2.
- FETCH_OP, MEM_WAIT=0:
  - Latch MEM_DATA into OPCODE.
  - Next state: n=0→VALID, otherwise FETCH_LO.
  - Decode n from MEM_DATA[7:6] in the same cycle.
- FETCH_LO, MEM_WAIT=0:
  - OPERAND[7:0]←MEM_DATA; OPERAND[15:8]←0.
  - Next state: n=1→VALID, n≥2→FETCH_HI.
- FETCH_HI, MEM_WAIT=0: OPERAND[15:8]←MEM_DATA; next state VALID.
- MEM_WAIT=1 in any fetch state: hold state and all registers; PC_INC=0.
- VALID:
  - INSN_VALID=1; OPCODE/OPERAND stable.
  - INSN_READY=1 → FETCH_OP next edge; otherwise hold.
- PC_INC = RST_bar & ~FLUSH & ~MEM_WAIT & (state ≠ VALID). Exactly one PC increment per byte latched.
- FLUSH=1, any state:
  - Next state FETCH_OP; PC_INC=0 this cycle.
  - OPCODE/OPERAND hold, except no byte is latched this cycle.
  - FLUSH overrides MEM_WAIT and INSN_READY.
  - Asserting FLUSH in VALID together with INSN_READY is the normal taken-branch case: the instruction is accepted and fetch restarts at the loaded PC.
- Reset (RST_bar=0 at edge):
  - State FETCH_OP; OPCODE=0x00; OPERAND=0x0000; INSN_VALID=0.
  - PC_INC is forced 0 while RST_bar=0.
  - Reset overrides every other input, including mid-instruction.

## Timing
- INSN_VALID is registered: it equals (state==VALID) and rises on the edge that enters VALID.
- PC_INC is combinational from state, MEM_WAIT, FLUSH and RST_bar. It must settle before the CLK edge at which the PC register increments.
- Latency, with no waits, from first FETCH_OP cycle to INSN_VALID high: n=0 → 1 edge; n=1 → 2 edges; n=2 → 3 edges.
- Each MEM_WAIT cycle adds exactly one cycle.
- Back-to-back throughput with INSN_READY held high: n+2 cycles per instruction (n+1 fetch cycles + 1 VALID cycle).
- OPCODE/OPERAND change only on edges where a byte is latched; they never change while INSN_VALID=1.

## Test plan
- Reset: hold RST_bar=0 for 2 edges from arbitrary state → STATE=0, INSN_VALID=0, OPCODE=0x00, OPERAND=0x0000, PC_INC=0.
- Zero-operand instruction: MEM_DATA=0x05, INSN_READY=1.
  - PC_INC=1 for 1 cycle.
  - Next cycle: INSN_VALID=1, OPCODE=0x05, OPERAND=0x0000.
  - FETCH_OP the cycle after.
- Two-byte operand: bytes 0x8A, 0x34, 0x12.
  - PC_INC high for 3 consecutive cycles.
  - Then OPCODE=0x8A, OPERAND=0x1234, INSN_VALID=1.
  - INSN_READY=0 for 4 cycles → outputs stable, PC_INC=0 throughout.
- Waits: opcode 0x41 with MEM_WAIT=1 for 2 cycles before the operand byte 0x7F.
  - PC_INC low during both waits.
  - Result: OPERAND=0x007F after 4 edges total.
- Flush mid-fetch: opcode 0x80, then FLUSH=1 in FETCH_LO.
  - PC_INC=0 that cycle; next STATE=0; OPERAND unchanged.
  - Fetch of the next byte 0x00 completes normally.
- Reset mid-instruction: RST_bar=0 while in FETCH_HI → next edge STATE=0, OPERAND=0x0000, INSN_VALID stays 0.
